// File: rtl/conv_kxk_mac_if.sv
// Stream bundle between the window generator, the KxK MAC core and the
// output-feature-map writer: window/weights/bias in, one pixel out.
interface conv_kxk_mac_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KSIZE      = 3
);
    localparam int WIN_W = DATA_WIDTH * KSIZE * KSIZE;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_first;
    logic [WIN_W-1:0]      win_pix;
    logic [WIN_W-1:0]      win_wgt;
    logic [DATA_WIDTH-1:0] bias;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_pixel;
    logic                  out_sat;
    logic                  ch_err;

    modport master (
        output in_valid, in_first, win_pix, win_wgt, bias, out_ready,
        input  in_ready, out_valid, out_pixel, out_sat, ch_err
    );

    modport slave (
        input  in_valid, in_first, win_pix, win_wgt, bias, out_ready,
        output in_ready, out_valid, out_pixel, out_sat, ch_err
    );
endinterface

// File: rtl/conv_kxk_mac.sv
// KxK convolution MAC: multiply (S1), accumulate CIN windows plus bias (S2),
// round/shift/ReLU/saturate into one output pixel (S3). One shared stall enable.
module conv_kxk_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int KSIZE      = 3,
    parameter int CIN        = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int QUANT      = 0,
    parameter int ROUND      = 1,
    parameter int RELU       = 0
) (
    input logic           clk,
    input logic           rst,
    conv_kxk_mac_if.slave io
);
    localparam int NELEM  = KSIZE * KSIZE;
    localparam int PW     = 2 * DATA_WIDTH;
    localparam int CW     = (CIN > 1) ? $clog2(CIN) : 1;
    localparam int RND_SH = (QUANT > 0) ? QUANT - 1 : 0;

    localparam logic [CW-1:0] LAST_CH = CW'(CIN - 1);
    localparam logic signed [ACC_WIDTH-1:0] RND =
        (ROUND != 0 && QUANT > 0) ? ACC_WIDTH'(1) << RND_SH : ACC_WIDTH'(0);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        (ACC_WIDTH'(1) << (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic          en;
    logic          xfer;
    logic [CW-1:0] ch_cnt;
    logic [CW-1:0] ch_eff;

    logic signed [PW-1:0]         prod     [NELEM];
    logic signed [PW-1:0]         s1_prod  [NELEM];
    logic signed [DATA_WIDTH-1:0] s1_bias;
    logic                         s1_valid;
    logic                         s1_first;
    logic                         s1_last;

    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic signed [ACC_WIDTH-1:0]  prod_sum;
    logic                         s2_valid;

    logic signed [ACC_WIDTH-1:0]  acc_rnd;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [DATA_WIDTH-1:0]        res_pix;
    logic                         res_sat;

    assign en          = !io.out_valid || io.out_ready;
    assign io.in_ready = en && !rst;
    assign xfer        = io.in_valid && io.in_ready;
    // A first-flagged window always restarts the group at channel 0.
    assign ch_eff      = io.in_first ? '0 : ch_cnt;

    always_comb begin
        for (int i = 0; i < NELEM; i++) begin
            prod[i] = PW'($signed(io.win_pix[i*DATA_WIDTH +: DATA_WIDTH]))
                    * PW'($signed(io.win_wgt[i*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    always_comb begin
        prod_sum = '0;
        for (int i = 0; i < NELEM; i++) begin
            prod_sum = prod_sum + ACC_WIDTH'(s1_prod[i]);
        end
        acc_next = (s1_first ? ACC_WIDTH'(s1_bias) : acc) + prod_sum;
    end

    always_comb begin
        acc_rnd = acc + RND;
        shifted = acc_rnd >>> QUANT;
        if (RELU != 0 && shifted < 0) begin
            shifted = '0;
        end
        res_pix = shifted[DATA_WIDTH-1:0];
        res_sat = 1'b0;
        if (shifted > SAT_MAX) begin
            res_pix = SAT_MAX[DATA_WIDTH-1:0];
            res_sat = 1'b1;
        end else if (shifted < SAT_MIN) begin
            res_pix = SAT_MIN[DATA_WIDTH-1:0];
            res_sat = 1'b1;
        end
    end

    // NOTE: product/bias registers are pure datapath qualified by s1_valid; they carry no reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            s1_prod <= prod;
            s1_bias <= io.bias;
        end
    end

    // NOTE: all state updates use non-blocking assignments so stages read pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt       <= '0;
            s1_valid     <= 1'b0;
            s1_first     <= 1'b0;
            s1_last      <= 1'b0;
            acc          <= '0;
            s2_valid     <= 1'b0;
            io.out_valid <= 1'b0;
            io.out_pixel <= '0;
            io.out_sat   <= 1'b0;
            io.ch_err    <= 1'b0;
        end else begin
            io.ch_err <= xfer && io.in_first && (ch_cnt != '0);
            if (en) begin
                s1_valid <= xfer;
                s1_first <= (ch_eff == '0);
                s1_last  <= (ch_eff == LAST_CH);
                if (xfer) begin
                    ch_cnt <= (ch_eff == LAST_CH) ? '0 : ch_eff + CW'(1);
                end
                if (s1_valid) begin
                    acc <= acc_next;
                end
                s2_valid     <= s1_valid && s1_last;
                io.out_valid <= s2_valid;
                if (s2_valid) begin
                    io.out_pixel <= res_pix;
                    io.out_sat   <= res_sat;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_kxk_mac.sv
// Bench for conv_kxk_mac: four parameterisations checked against an
// arithmetic reference model plus hand-computed literal results.
module tb_conv_kxk_mac;
    localparam int ND = 4;
    localparam int DW = 8;
    localparam int KS = 3;
    localparam int NE = KS * KS;
    localparam int WW = DW * NE;

    function automatic int p_cin(int d);   return (d < 2) ? 4 : 1; endfunction
    function automatic int p_quant(int d); return (d < 2) ? 0 : 2; endfunction
    function automatic int p_round(int d); return (d == 3) ? 0 : 1; endfunction
    function automatic int p_relu(int d);  return (d == 1) ? 1 : 0; endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [ND-1:0] in_valid, in_first, out_ready;
    logic [WW-1:0] win_pix [ND];
    logic [WW-1:0] win_wgt [ND];
    logic [DW-1:0] bias_v  [ND];
    wire  [ND-1:0] in_ready, out_valid, out_sat, ch_err;
    wire  [DW-1:0] out_pixel [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        conv_kxk_mac_if #(.DATA_WIDTH(DW), .KSIZE(KS)) bus ();
        assign bus.in_valid  = in_valid[g];
        assign bus.in_first  = in_first[g];
        assign bus.win_pix   = win_pix[g];
        assign bus.win_wgt   = win_wgt[g];
        assign bus.bias      = bias_v[g];
        assign bus.out_ready = out_ready[g];
        assign in_ready[g]   = bus.in_ready;
        assign out_valid[g]  = bus.out_valid;
        assign out_pixel[g]  = bus.out_pixel;
        assign out_sat[g]    = bus.out_sat;
        assign ch_err[g]     = bus.ch_err;
        conv_kxk_mac #(
            .DATA_WIDTH(DW), .KSIZE(KS), .CIN(p_cin(g)), .ACC_WIDTH(32),
            .QUANT(p_quant(g)), .ROUND(p_round(g)), .RELU(p_relu(g))
        ) dut (
            .clk(clk),
            .rst(rst),
            .io (bus.slave)
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int     d;
        longint pix;
        bit     sat;
    } rec_t;

    rec_t   exp_q[$];
    rec_t   got_q[$];
    int     m_cnt [ND];
    longint m_acc [ND];
    bit     m_err [ND];

    function automatic longint dot(int d);
        longint s = 0;
        for (int i = 0; i < NE; i++) begin
            s += longint'($signed(win_pix[d][i*DW +: DW])) * longint'($signed(win_wgt[d][i*DW +: DW]));
        end
        return s;
    endfunction

    function automatic rec_t finish_pixel(int d, longint acc);
        rec_t   r;
        longint t = acc;
        longint hi = (64'sd1 <<< (DW - 1)) - 1;
        longint lo = -(64'sd1 <<< (DW - 1));
        if (p_round(d) != 0 && p_quant(d) > 0) t += 64'sd1 <<< (p_quant(d) - 1);
        t = t >>> p_quant(d);
        if (p_relu(d) != 0 && t < 0) t = 0;
        r.d = d;
        r.sat = 1'b0;
        r.pix = t;
        if (t > hi) begin r.pix = hi; r.sat = 1'b1; end
        if (t < lo) begin r.pix = lo; r.sat = 1'b1; end
        return r;
    endfunction

    always @(negedge clk) begin : compare
        int   idx;
        int   ch;
        bit   xf;
        rec_t r;
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                m_cnt[d] = 0;
                m_acc[d] = 0;
                m_err[d] = 1'b0;
                for (int i = exp_q.size() - 1; i >= 0; i--) begin
                    if (exp_q[i].d == d) exp_q.delete(i);
                end
                check($sformatf("d%0d_rst_valid", d), out_valid[d], 0);
            end else begin
                check($sformatf("d%0d_ch_err", d), ch_err[d], m_err[d]);
                check($sformatf("d%0d_in_ready", d), in_ready[d], !out_valid[d] || out_ready[d]);
                if (out_valid[d]) begin
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (idx < 0 && exp_q[i].d == d) idx = i;
                    end
                    if (idx < 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL d%0d_unexpected: got pixel %0d, expected no output", d, $signed(out_pixel[d]));
                    end else begin
                        check($sformatf("d%0d_pixel", d), $signed(out_pixel[d]), exp_q[idx].pix);
                        check($sformatf("d%0d_sat", d), out_sat[d], exp_q[idx].sat);
                        if (out_ready[d]) exp_q.delete(idx);
                    end
                    if (out_ready[d]) begin
                        r.d = d;
                        r.pix = longint'($signed(out_pixel[d]));
                        r.sat = out_sat[d];
                        got_q.push_back(r);
                    end
                end
                xf = in_valid[d] && in_ready[d];
                m_err[d] = xf && in_first[d] && (m_cnt[d] != 0);
                if (xf) begin
                    ch = in_first[d] ? 0 : m_cnt[d];
                    if (ch == 0) m_acc[d] = longint'($signed(bias_v[d]));
                    m_acc[d] += dot(d);
                    if (ch == p_cin(d) - 1) begin
                        exp_q.push_back(finish_pixel(d, m_acc[d]));
                        m_cnt[d] = 0;
                    end else begin
                        m_cnt[d] = ch + 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [WW-1:0] fill(int v);
        logic [DW-1:0] b = v[DW-1:0];
        return {NE{b}};
    endfunction

    function automatic logic [WW-1:0] one(int v);
        logic [WW-1:0] w = '0;
        w[DW-1:0] = v[DW-1:0];
        return w;
    endfunction

    task automatic send(input logic [ND-1:0] mask, input bit first,
                        input logic [WW-1:0] pix, input logic [WW-1:0] wgt, input int b);
        bit done = 1'b0;
        int guard = 0;
        for (int d = 0; d < ND; d++) begin
            if (mask[d]) begin
                in_valid[d] = 1'b1;
                in_first[d] = first;
                win_pix[d]  = pix;
                win_wgt[d]  = wgt;
                bias_v[d]   = b[DW-1:0];
            end
        end
        while (!done) begin
            @(negedge clk);
            done = ((in_ready & mask) == mask);
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: got no in_ready after %0d cycles, expected transfer", guard);
                done = 1'b1;
            end
        end
        in_valid = in_valid & ~mask;
        in_first = in_first & ~mask;
    endtask

    task automatic group(input logic [ND-1:0] mask, input logic [WW-1:0] pix,
                         input logic [WW-1:0] wgt, input int b);
        for (int c = 0; c < 4; c++) send(mask, c == 0, pix, wgt, b);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic expect_got(input string name, input int d, input int pix, input bit sat);
        rec_t r;
        if (got_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no output, expected pixel %0d", name, pix);
        end else begin
            r = got_q.pop_front();
            check({name, "_dut"}, r.d, d);
            check(name, r.pix, pix);
            check({name, "_sat"}, r.sat, sat);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int edges;
        in_valid  = '0;
        in_first  = '0;
        out_ready = '1;
        for (int d = 0; d < ND; d++) begin
            win_pix[d] = '0;
            win_wgt[d] = '0;
            bias_v[d]  = '0;
        end
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pixel", out_pixel[0], 0);
        check("rst_sat", out_sat[0], 0);
        check("rst_ch_err", ch_err[0], 0);
        check("rst_in_ready", in_ready[0], 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic sum and latency: 4 * 9 + 5 = 41, valid two edges after the last transfer.
        got_q.delete();
        send(1, 1'b1, fill(1), fill(1), 5);
        for (int c = 1; c < 4; c++) send(1, 1'b0, fill(1), fill(1), 5);
        edges = 0;
        while (!out_valid[0] && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency_edges", edges, 2);
        settle();
        expect_got("sum41", 0, 41, 1'b0);

        // Saturation both ways.
        group(1, fill(127), fill(127), 0);
        settle();
        expect_got("sat_pos", 0, 127, 1'b1);
        group(1, fill(-128), fill(127), 0);
        settle();
        expect_got("sat_neg", 0, -128, 1'b1);

        // Backpressure: 12 windows, downstream stalled across the first result.
        got_q.delete();
        out_ready[0] = 1'b0;
        fork
            begin
                group(1, fill(1), fill(2), -50);
                group(1, fill(-1), fill(3), 7);
                for (int c = 0; c < 4; c++) send(1, c == 0, fill(c + 1), fill(1), -3);
            end
            begin
                int guard = 0;
                do begin
                    @(negedge clk);
                    guard++;
                end while (!out_valid[0] && guard < 100);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    check("stall_valid", out_valid[0], 1);
                    check("stall_in_ready", in_ready[0], 0);
                    check("stall_hold", $signed(out_pixel[0]), 22);
                end
                @(posedge clk);
                #1;
                out_ready[0] = 1'b1;
            end
        join
        settle();
        expect_got("bp_0", 0, 22, 1'b0);
        expect_got("bp_1", 0, -101, 1'b0);
        expect_got("bp_2", 0, 87, 1'b0);
        check("bp_no_dup", got_q.size(), 0);

        // Resync on the 3rd window: partial group dropped, new group 4*9 + 3 = 39.
        send(1, 1'b1, fill(5), fill(5), 9);
        send(1, 1'b0, fill(5), fill(5), 0);
        send(1, 1'b1, fill(1), fill(1), 3);
        check("ch_err_pulse", ch_err[0], 1);
        for (int c = 1; c < 4; c++) send(1, 1'b0, fill(1), fill(1), 0);
        check("ch_err_cleared", ch_err[0], 0);
        settle();
        expect_got("resync", 0, 39, 1'b0);

        // Reset mid-group with a finished result sitting in the output register.
        group(1, fill(1), fill(1), 5);
        send(1, 1'b1, fill(2), fill(2), 1);
        send(1, 1'b0, fill(2), fill(2), 1);
        check("pre_rst_pixel", $signed(out_pixel[0]), 41);
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid[0], 0);
        check("async_rst_pixel", out_pixel[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        for (int c = 0; c < 4; c++) send(1, 1'b0, fill(1), fill(1), 5);
        settle();
        expect_got("post_rst", 0, 41, 1'b0);

        // ReLU core.
        group(2, fill(-1), fill(1), 0);
        settle();
        expect_got("relu_neg", 1, 0, 1'b0);
        group(2, fill(1), fill(1), 0);
        settle();
        expect_got("relu_pos", 1, 36, 1'b0);

        // QUANT=2, CIN=1: rounded core (2) and truncating core (3) side by side.
        send(4'b1100, 1'b1, one(-2), one(3), 0);
        send(4'b1100, 1'b0, one(6), one(7), 0);
        settle();
        expect_got("q_rnd_m6", 2, -1, 1'b0);
        expect_got("q_trn_m6", 3, -2, 1'b0);
        expect_got("q_rnd_42", 2, 11, 1'b0);
        expect_got("q_trn_42", 3, 10, 1'b0);

        check("all_delivered", exp_q.size(), 0);
        check("no_extra_output", got_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL global_timeout: got still running, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/conv_kxk_mac.md
# conv_kxk_mac

Parametrised KxK convolution MAC core. Each cycle it accepts one KxK pixel window and its weights, and accumulates CIN consecutive windows (one per input channel) plus a bias. It then rounds, shifts, optionally applies ReLU, saturates, and emits one DATA_WIDTH output pixel. It sits between the line-buffer/window generator and the output-feature-map writer, with valid/ready flow control on both sides.

## Interface
- DATA_WIDTH, 8, signed pixel/weight/bias/output width
- KSIZE, 3, kernel edge; window holds KSIZE*KSIZE elements
- CIN, 4, windows (input channels) accumulated per output pixel; >=1
- ACC_WIDTH, 32, signed accumulator width; must be >= 2*DATA_WIDTH + clog2(KSIZE*KSIZE*CIN) + 1
- QUANT, 0, arithmetic right shift applied to accumulator; 0..ACC_WIDTH-1
- ROUND, 1, 1: round-half-up before shift; 0: truncate
- RELU, 0, 1: clamp negative results to 0 before saturation

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  window/weights/bias valid
- in_ready  out  1  core can accept; transfer when in_valid && in_ready
- in_first  in  1  window is channel 0 of a new output pixel
- win_pix  in  DATA_WIDTH*KSIZE*KSIZE  signed pixels, element r*KSIZE+c at bits [(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH]
- win_wgt  in  DATA_WIDTH*KSIZE*KSIZE  signed weights, same packing
- bias  in  DATA_WIDTH  signed bias, sampled only with channel-0 window
- out_valid  out  1  out_pixel valid
- out_ready  in  1  downstream accepts
- out_pixel  out  DATA_WIDTH  signed result
- out_sat  out  1  qualifies out_pixel: result was clamped by saturation
- ch_err  out  1  one-cycle pulse: in_first seen with partial group pending

## Operation
- Accept: transfer = in_valid && in_ready. Internal ch_cnt (0..CIN-1) tags each accepted window; increments on transfer, wraps CIN-1 -> 0.
- Resync: transfer with in_first=1 is forced to channel 0. If ch_cnt != 0 at that moment, the partial group is discarded and ch_err pulses for one cycle. in_first=1 with ch_cnt=0 is normal. Windows with in_first=0 follow ch_cnt.
- Stage S1: register KSIZE*KSIZE signed products (2*DATA_WIDTH bits each), plus valid, first and last (channel==CIN-1) flags, plus bias.
- Stage S2: acc <= (first ? sext(bias) : acc) + sum of sign-extended products. The bias is added unshifted at accumulator scale. When last, raise result-valid; otherwise no output. CIN=1: every window is first and last.
- Stage S3: t = acc + (ROUND && QUANT>0 ? 1<<(QUANT-1) : 0); s = t >>> QUANT; if RELU and s<0, s=0; saturate s to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Register out_pixel, out_sat (1 iff the clamp changed the value; ReLU clamp does not set it), and out_valid.
- Accumulator overflow when the ACC_WIDTH rule is violated: wraps silently; not detected.

## Timing
- Advance enable en = !out_valid || out_ready. All stages, ch_cnt and the S3 register update only when en=1. A full stall freezes every stage and holds out_pixel/out_sat stable.
- in_ready = en && !rst (combinational). Throughput: one window per cycle when not stalled; one output per CIN accepted windows.
- Latency: last-channel window transferred at edge E -> out_valid high after edge E+2, i.e. visible in the third cycle counting the transfer cycle.
- out_valid drops after the edge where out_valid && out_ready, unless a new result enters S3 at the same edge, in which case it stays high with the new pixel.
- Reset (async, any time): out_valid=0, out_pixel=0, out_sat=0, ch_err=0, ch_cnt=0, all stage valids=0, acc=0. Partial groups and in-flight results are lost. First transfer after release is channel 0.
- Simultaneous in_first resync and stall: nothing happens until en=1. The resync and ch_err occur on the transferring edge.

## Test plan
- K=3, CIN=4, Q=0: all pix=1, wgt=1, bias=5, four back-to-back windows -> single out_pixel=41, out_sat=0, out_valid exactly 2 edges after the 4th transfer.
- Saturation: pix=127, wgt=127, 4 channels -> out_pixel=127, out_sat=1. Pix=-128, wgt=127 -> out_pixel=-128, out_sat=1.
- RELU=1, pix=-1, wgt=1, bias=0 -> sum -36 -> out_pixel=0, out_sat=0.
- QUANT=2: accumulated value -6 (CIN=1, one product -6, bias 0) -> ROUND=1 gives -1, ROUND=0 gives -2. Value 42 -> 11 rounded, 10 truncated.
- Backpressure: stream 12 windows (3 pixels) with out_ready low for 5 cycles mid-stream -> in_ready low while stalled, out_pixel held, all 3 results delivered in order, none duplicated.
- Resync/reset: assert in_first on the 3rd window of a group -> ch_err one pulse, next output uses only the 4 windows from the resync point. Assert rst mid-group -> outputs zero immediately, next full group gives the correct value.
